// File: rtl/fft_pkg.sv
// Shared FFT word layout: points per frame, component width and the packed bin format.
// The analysis stage imports this package too, so any change to bin_t affects both sides.
package fft_pkg;

  localparam int NPT      = 16;
  localparam int DW       = 16;
  localparam int LOG2_NPT = 4;

  // Packed bin as seen on every fft_dN word: {real, imag}.
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } bin_t;

  function automatic logic [LOG2_NPT-1:0] bitrev4(input logic [LOG2_NPT-1:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/fft_collect.sv
// Serial-to-parallel collector: assembles 16 streamed FFT bins into a held frame for the analysis stage.
// Define FFT_COLLECT_BITREV_EN to store bin k in slot bitrev4(k) (undoes bit-reversed source order).
module fft_collect #(
  parameter int DW           = 16,
  parameter int NPT          = 16,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  input  logic                 ana_done,
  output logic                 fft_valid,
  output logic [2*DW-1:0]      fft_d0,
  output logic [2*DW-1:0]      fft_d1,
  output logic [2*DW-1:0]      fft_d2,
  output logic [2*DW-1:0]      fft_d3,
  output logic [2*DW-1:0]      fft_d4,
  output logic [2*DW-1:0]      fft_d5,
  output logic [2*DW-1:0]      fft_d6,
  output logic [2*DW-1:0]      fft_d7,
  output logic [2*DW-1:0]      fft_d8,
  output logic [2*DW-1:0]      fft_d9,
  output logic [2*DW-1:0]      fft_d10,
  output logic [2*DW-1:0]      fft_d11,
  output logic [2*DW-1:0]      fft_d12,
  output logic [2*DW-1:0]      fft_d13,
  output logic [2*DW-1:0]      fft_d14,
  output logic [2*DW-1:0]      fft_d15,
  output logic                 frame_err,
  output logic                 timeout_err
);

  import fft_pkg::*;

  // Timeout counter spans 0..DONE_TIMEOUT-1; the last value is the expiry point.
  localparam int              TW       = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam bit              TMO_EN   = (DONE_TIMEOUT > 0);
  localparam logic [TW-1:0]   TMO_LAST = TW'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);

  logic [LOG2_NPT-1:0] wr_cnt_reg, wr_cnt_next;
  logic [LOG2_NPT-1:0] wr_idx, wr_slot;
  logic                pending_reg, pending_next;
  logic                ds_busy_reg, ds_busy_next;
  logic                fft_valid_reg, fft_valid_next;
  logic                frame_err_reg, frame_err_next;
  logic                timeout_err_reg, timeout_err_next;
  logic [TW-1:0]       tmo_cnt_reg, tmo_cnt_next;

  logic                accept, issue, resync, tmo_hit;
  logic [NPT-1:0]      slot_we;
  bin_t                in_bin;
  bin_t                fill_mem  [NPT];
  bin_t                fft_d_reg [NPT];

  assign in_ready = !pending_reg;
  assign accept   = in_valid && !pending_reg;
  assign issue    = pending_reg && !ds_busy_reg;
  assign resync   = accept && in_sop && (wr_cnt_reg != '0);
  assign tmo_hit  = TMO_EN && ds_busy_reg && !ana_done && (tmo_cnt_reg == TMO_LAST);
  assign in_bin   = '{re: in_real, im: in_imag};

`ifdef FFT_COLLECT_BITREV_EN
  assign wr_idx = bitrev4(wr_cnt_reg);
`else
  assign wr_idx = wr_cnt_reg;
`endif

  // A resync bin is always bin 0 of the new frame, which is slot 0 in either ordering.
  assign wr_slot = resync ? '0 : wr_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NPT; gi++) begin : g_slot_we
      assign slot_we[gi] = accept && (wr_slot == LOG2_NPT'(gi));
    end
  endgenerate

  always_comb begin
    wr_cnt_next      = wr_cnt_reg;
    pending_next     = pending_reg;
    ds_busy_next     = ds_busy_reg;
    fft_valid_next   = 1'b0;
    frame_err_next   = frame_err_reg;
    timeout_err_next = timeout_err_reg;
    tmo_cnt_next     = tmo_cnt_reg;

    if (accept) begin
      if (resync) begin
        wr_cnt_next    = LOG2_NPT'(1);
        frame_err_next = 1'b1;
      end else begin
        wr_cnt_next = wr_cnt_reg + 1'b1;
        if (wr_cnt_reg == '1) pending_next = 1'b1;
      end
    end

    // issue requires !ds_busy and done/timeout require ds_busy, so these never overlap.
    if (issue) begin
      pending_next   = 1'b0;
      ds_busy_next   = 1'b1;
      fft_valid_next = 1'b1;
      tmo_cnt_next   = '0;
    end else if (ds_busy_reg) begin
      if (ana_done) begin
        ds_busy_next = 1'b0;
        tmo_cnt_next = '0;
      end else if (tmo_hit) begin
        ds_busy_next     = 1'b0;
        timeout_err_next = 1'b1;
        tmo_cnt_next     = '0;
      end else if (TMO_EN) begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_cnt_reg      <= '0;
      pending_reg     <= 1'b0;
      ds_busy_reg     <= 1'b0;
      fft_valid_reg   <= 1'b0;
      frame_err_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      tmo_cnt_reg     <= '0;
    end else begin
      wr_cnt_reg      <= wr_cnt_next;
      pending_reg     <= pending_next;
      ds_busy_reg     <= ds_busy_next;
      fft_valid_reg   <= fft_valid_next;
      frame_err_reg   <= frame_err_next;
      timeout_err_reg <= timeout_err_next;
      tmo_cnt_reg     <= tmo_cnt_next;
    end
  end

  // Fill buffer is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPT; i++) begin
      if (slot_we[i]) fill_mem[i] <= in_bin;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NPT; i++) fft_d_reg[i] <= '0;
    end else if (issue) begin
      for (int i = 0; i < NPT; i++) fft_d_reg[i] <= fill_mem[i];
    end
  end

  assign fft_valid   = fft_valid_reg;
  assign frame_err   = frame_err_reg;
  assign timeout_err = timeout_err_reg;

  assign fft_d0  = fft_d_reg[0];
  assign fft_d1  = fft_d_reg[1];
  assign fft_d2  = fft_d_reg[2];
  assign fft_d3  = fft_d_reg[3];
  assign fft_d4  = fft_d_reg[4];
  assign fft_d5  = fft_d_reg[5];
  assign fft_d6  = fft_d_reg[6];
  assign fft_d7  = fft_d_reg[7];
  assign fft_d8  = fft_d_reg[8];
  assign fft_d9  = fft_d_reg[9];
  assign fft_d10 = fft_d_reg[10];
  assign fft_d11 = fft_d_reg[11];
  assign fft_d12 = fft_d_reg[12];
  assign fft_d13 = fft_d_reg[13];
  assign fft_d14 = fft_d_reg[14];
  assign fft_d15 = fft_d_reg[15];

endmodule

// File: tb/tb_fft_collect.sv
// Self-checking bench for fft_collect: randomized bins checked against a frame-level reference model.
// Honors FFT_COLLECT_BITREV_EN so the same bench covers both slot orderings.
module tb_fft_collect;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_sop, ana_done;
  logic [15:0] in_real, in_imag;
  logic        in_ready, fft_valid, frame_err, timeout_err;
  logic [31:0] fft_d0, fft_d1, fft_d2, fft_d3, fft_d4, fft_d5, fft_d6, fft_d7;
  logic [31:0] fft_d8, fft_d9, fft_d10, fft_d11, fft_d12, fft_d13, fft_d14, fft_d15;
  logic [31:0] d [16];

  int checks   = 0;
  int failures = 0;
  int pcyc     = 0;

`ifdef FFT_COLLECT_BITREV_EN
  localparam bit BITREV = 1'b1;
`else
  localparam bit BITREV = 1'b0;
`endif

  logic [31:0] stim      [32];
  logic [31:0] exp_frame [16];
  logic [31:0] frame_a   [16];

  always #5 clk = ~clk;
  always @(posedge clk) pcyc <= pcyc + 1;

  fft_collect #(.DW(16), .NPT(16), .DONE_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_real(in_real), .in_imag(in_imag), .ana_done(ana_done), .fft_valid(fft_valid),
    .fft_d0(fft_d0), .fft_d1(fft_d1), .fft_d2(fft_d2), .fft_d3(fft_d3),
    .fft_d4(fft_d4), .fft_d5(fft_d5), .fft_d6(fft_d6), .fft_d7(fft_d7),
    .fft_d8(fft_d8), .fft_d9(fft_d9), .fft_d10(fft_d10), .fft_d11(fft_d11),
    .fft_d12(fft_d12), .fft_d13(fft_d13), .fft_d14(fft_d14), .fft_d15(fft_d15),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  assign d[0]  = fft_d0;  assign d[1]  = fft_d1;  assign d[2]  = fft_d2;  assign d[3]  = fft_d3;
  assign d[4]  = fft_d4;  assign d[5]  = fft_d5;  assign d[6]  = fft_d6;  assign d[7]  = fft_d7;
  assign d[8]  = fft_d8;  assign d[9]  = fft_d9;  assign d[10] = fft_d10; assign d[11] = fft_d11;
  assign d[12] = fft_d12; assign d[13] = fft_d13; assign d[14] = fft_d14; assign d[15] = fft_d15;

  // Reference: where bin k of a frame should appear on the output words.
  function automatic int slot_of(input int k);
    if (BITREV) return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
    return k;
  endfunction

  // First output word that disagrees with exp_frame, or -1.
  function automatic int first_bad();
    for (int k = 0; k < 16; k++) begin
      if (d[slot_of(k)] !== exp_frame[k]) return slot_of(k);
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    ana_done = 1'b1;
    tick();
    ana_done = 1'b0;
  endtask

  task automatic randomize_stim();
    for (int i = 0; i < 32; i++) stim[i] = $urandom;
  endtask

  // Streams stim[start .. start+n-1]; returns in the cycle after the last bin was accepted.
  task automatic send_seq(input int start, input int n, input bit sop_first, input int max_gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sop   = sop_first && (i == 0);
      in_real  = stim[start + i][31:16];
      in_imag  = stim[start + i][15:0];
      guard    = 0;
      while (!in_ready && guard < 200) begin
        tick();
        guard++;
      end
      checks++;
      if (guard >= 200) begin
        failures++;
        $display("FAIL accept_wait: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
      end
      tick();
      if (max_gap > 0 && i != n - 1) begin
        in_valid = 1'b0;
        in_sop   = 1'b0;
        repeat ($urandom_range(0, max_gap)) tick();
      end
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (fft_valid !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (fft_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait: fft_valid=%0b after %0d cycles, required 1", name, fft_valid, n);
    end
  endtask

  task automatic test_reset();
    bit any_nz = 0;
    rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; ana_done = 1'b0; in_real = '0; in_imag = '0;
    repeat (3) tick();
    for (int s = 0; s < 16; s++) if (d[s] !== 32'h0) any_nz = 1;
    checks++;
    if ({fft_valid, frame_err, timeout_err} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: valid/frame_err/timeout_err=%b, required 000", {fft_valid, frame_err, timeout_err});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%0b, required 1", in_ready);
    end
    checks++;
    if (any_nz) begin
      failures++;
      $display("FAIL reset_data: fft_d nonzero (d0=%h d15=%h), required all 0", d[0], d[15]);
    end
    rst = 1'b1;
    tick();
    $display("reset: flags=%b ready=%0b", {fft_valid, frame_err, timeout_err}, in_ready);
  endtask

  task automatic test_basic();
    int bad;
    for (int k = 0; k < 16; k++) begin
      stim[k]      = {k[15:0], 16'(-k)};
      exp_frame[k] = stim[k];
    end
    send_seq(0, 16, 1'b1, 0);
    checks++;
    if ({in_ready, fft_valid} !== 2'b00) begin
      failures++;
      $display("FAIL basic_t1: ready/valid=%b, required 00", {in_ready, fft_valid});
    end
    tick();
    checks++;
    if ({in_ready, fft_valid} !== 2'b11) begin
      failures++;
      $display("FAIL basic_t2: ready/valid=%b, required 11", {in_ready, fft_valid});
    end
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL basic_frame: slot %0d got %h", bad, d[bad]);
    end
    checks++;
    if (fft_d5 !== (BITREV ? 32'h000A_FFF6 : 32'h0005_FFFB)) begin
      failures++;
      $display("FAIL basic_d5: fft_d5=%h", fft_d5);
    end
    checks++;
    if ({fft_d8[31:16], fft_d12[31:16], fft_d15[31:16]} !==
        (BITREV ? {16'd1, 16'd3, 16'd15} : {16'd8, 16'd12, 16'd15})) begin
      failures++;
      $display("FAIL basic_order: d8/d12/d15 real=%0d/%0d/%0d", fft_d8[31:16], fft_d12[31:16], fft_d15[31:16]);
    end
    tick();
    checks++;
    if (fft_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse: fft_valid=%0b one cycle later, required 0", fft_valid);
    end
    pulse_done();
    $display("basic: d0=%h d5=%h d15=%h", fft_d0, fft_d5, fft_d15);
  endtask

  task automatic test_back_to_back();
    int bad;
    bit leak = 0;
    randomize_stim();
    for (int k = 0; k < 16; k++) begin
      frame_a[k]   = stim[k];
      exp_frame[k] = stim[k];
    end
    send_seq(0, 16, 1'b1, 2);
    wait_valid("bp_a");
    bad = first_bad();
    checks++;
    if (bad != -1) begin
      failures++;
      $display("FAIL bp_frame_a: slot %0d got %h", bad, d[bad]);
    end
    send_seq(16, 16, 1'b1, 0);
    repeat (6) begin
      if (in_ready !== 1'b0 || fft_valid !== 1'b0) leak = 1;
      tick();
    end
    checks++;
    if (leak) begin
      failures++;
      $display("FAIL bp_stall: ready/valid=%b while busy, required 00", {in_ready, fft_valid});
    end
    pulse_done();
    bad = first_bad();
    checks++;
    if (fft_valid !== 1'b0 || bad != -1) begin
      failures++;
      $display("FAIL bp_hold: valid=%0b bad_slot=%0d, required 0 and -1", fft_valid, bad);
    end
    tick();
    for (int k = 0; k < 16; k++) exp_frame[k] = stim[16 + k];
    bad = first_bad();
    checks++;
    if (fft_valid !== 1'b1 || bad != -1) begin
      failures++;
      $display("FAIL bp_frame_b: valid=%0b bad_slot=%0d, required 1 and -1", fft_valid, bad);
    end
    // done coincident with fft_valid retires frame B, so frame C must issue at normal latency
    pulse_done();
    randomize_stim();
    for (int k = 0; k < 16; k++) exp_frame[k] = stim[k];
    send_seq(0, 16, 1'b1, 0);
    tick();
    bad = first_bad();
    checks++;
    if (fft_valid !== 1'b1 || bad != -1) begin
      failures++;
      $display("FAIL b2b_frame_c: valid=%0b bad_slot=%0d, required 1 and -1", fft_valid, bad);
    end
    pulse_done();
    $display("back_to_back: frames A,B,C issued, last d0=%h", fft_d0);
  endtask

  task automatic test_sync();
    int bad;
    checks++;
    if (frame_err !== 1'b0) begin
      failures++;
      $display("FAIL sync_pre: frame_err=%0b, required 0", frame_err);
    end
    randomize_stim();
    stim[7][31:16] = 16'd100;
    send_seq(0, 7, 1'b1, 0);
    send_seq(7, 1, 1'b1, 0);
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_err: frame_err=%0b, required 1", frame_err);
    end
    send_seq(8, 15, 1'b0, 1);
    tick();
    for (int k = 0; k < 16; k++) exp_frame[k] = stim[7 + k];
    bad = first_bad();
    checks++;
    if (fft_valid !== 1'b1 || bad != -1 || fft_d0[31:16] !== 16'd100) begin
      failures++;
      $display("FAIL sync_frame: valid=%0b bad_slot=%0d d0=%h, required 1, -1, 0064xxxx", fft_valid, bad, fft_d0);
    end
    pulse_done();
    checks++;
    if (frame_err !== 1'b1) begin
      failures++;
      $display("FAIL sync_sticky: frame_err=%0b, required 1", frame_err);
    end
    $display("sync: frame_err=%0b d0=%h", frame_err, fft_d0);
  endtask

  task automatic test_timeout();
    int va, vb, terr, n, bad;
    terr = -1;
    randomize_stim();
    send_seq(0, 16, 1'b1, 0);
    wait_valid("tmo_a");
    va = pcyc;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_pre: timeout_err=%0b, required 0", timeout_err);
    end
    send_seq(16, 16, 1'b1, 0);
    n = 0;
    while (fft_valid !== 1'b1 && n < 200) begin
      if (timeout_err === 1'b1 && terr < 0) terr = pcyc;
      tick();
      n++;
    end
    vb = pcyc;
    checks++;
    if (terr - va != 64) begin
      failures++;
      $display("FAIL tmo_delay: timeout_err rose %0d cycles after issue, required 64", terr - va);
    end
    checks++;
    if (fft_valid !== 1'b1 || vb - terr != 1) begin
      failures++;
      $display("FAIL tmo_next_issue: valid=%0b at %0d cycles after timeout, required 1 at 1", fft_valid, vb - terr);
    end
    for (int k = 0; k < 16; k++) exp_frame[k] = stim[16 + k];
    bad = first_bad();
    checks++;
    if (bad != -1 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_frame_b: bad_slot=%0d timeout_err=%0b, required -1 and 1", bad, timeout_err);
    end
    $display("timeout: err after %0d cycles, next frame d0=%h", terr - va, fft_d0);
  endtask

  task automatic test_reset_mid();
    int bad;
    randomize_stim();
    send_seq(0, 10, 1'b1, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if ({in_ready, fft_valid, frame_err, timeout_err} !== 4'b1000 || fft_d0 !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_state: ready/valid/ferr/terr=%b d0=%h, required 1000 and 0",
               {in_ready, fft_valid, frame_err, timeout_err}, fft_d0);
    end
    randomize_stim();
    for (int k = 0; k < 16; k++) exp_frame[k] = stim[k];
    send_seq(0, 16, 1'b0, 0);
    tick();
    bad = first_bad();
    checks++;
    if (fft_valid !== 1'b1 || frame_err !== 1'b0 || bad != -1) begin
      failures++;
      $display("FAIL rstmid_frame: valid=%0b frame_err=%0b bad_slot=%0d, required 1, 0, -1", fft_valid, frame_err, bad);
    end
    pulse_done();
    $display("reset_mid: clean frame d0=%h frame_err=%0b", fft_d0, frame_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_sync();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
